// File: rtl/mult_arbiter_n.sv
// Two-client arbiter/sequencer for a shared two-register reg_mult_n.
// Define MULT_ARB_RR_EN for round-robin; fixed priority (client 0) otherwise.
module mult_arbiter_n #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [N-1:0] res,
    output logic         busy,
    output logic         m_ea,
    output logic         m_eb,
    output logic [N-1:0] m_a,
    output logic [N-1:0] m_b,
    input  logic [N-1:0] m_p
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t       state_q, state_d;
    logic         id_q, id_d;
    logic [N-1:0] res_q, res_d;
    logic [1:0]   done_q, done_d;
    logic [N-1:0] m_a_q, m_a_d;
    logic [N-1:0] m_b_q, m_b_d;
    logic         win;

`ifdef MULT_ARB_RR_EN
    logic last_q, last_d;

    // On contention the client not served last time wins.
    always_comb begin
        win = 1'b0;
        if (req[0] && req[1]) begin
            win = ~last_q;
        end else begin
            win = req[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        win = ~req[0];
    end
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        res_d   = res_q;
        done_d  = 2'b00;
        m_a_d   = m_a_q;
        m_b_d   = m_b_q;
        gnt     = 2'b00;
        m_ea    = 1'b0;
        m_eb    = 1'b0;
`ifdef MULT_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_LOAD;
                    id_d    = win;
                    m_a_d   = win ? a1 : a0;
                    m_b_d   = win ? b1 : b0;
`ifdef MULT_ARB_RR_EN
                    last_d  = win;
`endif
                end
            end
            ST_LOAD: begin
                gnt     = id_q ? 2'b10 : 2'b01;
                m_ea    = 1'b1;
                m_eb    = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                res_d   = m_p;
                done_d  = id_q ? 2'b10 : 2'b01;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            id_q    <= 1'b0;
            res_q   <= '0;
            done_q  <= 2'b00;
            m_a_q   <= '0;
            m_b_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            res_q   <= res_d;
            done_q  <= done_d;
            m_a_q   <= m_a_d;
            m_b_q   <= m_b_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign res  = res_q;
    assign done = done_q;
    assign m_a  = m_a_q;
    assign m_b  = m_b_q;

endmodule
